// File: rtl/sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute control for a small
// register machine. Strobes are decoded from the state and the latched IR only.
module sequencer #(
    parameter int INST_ADDR_WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_run,
    input  logic [15:0]                i_instruction,
    input  logic                       i_zero,
    input  logic                       i_neg,
    output logic [15:0]                o_ir,
    output logic                       o_inc_pc,
    output logic                       o_load_pc,
    output logic                       o_load_ram,
    output logic [INST_ADDR_WIDTH-1:0] o_jump_addr,
    output logic [3:0]                 o_reg_we,
    output logic [1:0]                 o_dest_sel,
    output logic [1:0]                 o_src_sel,
    output logic [1:0]                 o_wb_sel,
    output logic [2:0]                 o_state,
    output logic                       o_halted,
    output logic                       o_illegal,
    output logic [15:0]                o_inst_count
);

    localparam logic [2:0] ST_FETCH    = 3'd0;
    localparam logic [2:0] ST_DECODE   = 3'd1;
    localparam logic [2:0] ST_EXECUTE  = 3'd2;
    localparam logic [2:0] ST_MEM_WAIT = 3'd3;
    localparam logic [2:0] ST_HALT     = 3'd4;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_SHIFT = 4'd4;
    localparam logic [3:0] OP_LOAD  = 4'd5;
    localparam logic [3:0] OP_STORE = 4'd6;
    localparam logic [3:0] OP_MOVE  = 4'd7;
    localparam logic [3:0] OP_JUMP  = 4'd8;
    localparam logic [3:0] OP_LOADC = 4'd9;

    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_RAM   = 2'b01;
    localparam logic [1:0] WB_REG   = 2'b10;
    localparam logic [1:0] WB_CONST = 2'b11;

    logic [2:0]  state_r;
    logic [2:0]  state_next_s;
    logic [15:0] ir_r;
    logic        illegal_r;
    logic [15:0] count_r;
    logic [3:0]  opcode_s;
    logic        inc_pc_s;
    logic        load_pc_s;
    logic        load_ram_s;
    logic [3:0]  reg_we_s;
    logic [1:0]  wb_sel_s;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] vec;
        vec = 4'b0000;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    function automatic logic jump_taken(input logic [1:0] cond, input logic zero, input logic neg);
        logic taken;
        case (cond)
            2'b00:   taken = 1'b1;
            2'b01:   taken = zero;
            2'b10:   taken = neg;
            2'b11:   taken = 1'b0;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    assign opcode_s = ir_r[15:12];

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; unused encodings fall into HALT
    always_comb begin
        state_next_s = ST_HALT;
        case (state_r)
            ST_FETCH: begin
                if (i_run) begin
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE:   state_next_s = ST_EXECUTE;
            ST_EXECUTE: begin
                if (opcode_s == OP_LOAD) begin
                    state_next_s = ST_MEM_WAIT;
                end else if (opcode_s >= 4'd10) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_MEM_WAIT: state_next_s = ST_FETCH;
            ST_HALT:     state_next_s = ST_HALT;
            default:     state_next_s = ST_HALT;
        endcase
    end

    // Strobe decode from state and latched IR only
    always_comb begin
        inc_pc_s   = 1'b0;
        load_pc_s  = 1'b0;
        load_ram_s = 1'b0;
        reg_we_s   = 4'b0000;
        wb_sel_s   = WB_ALU;
        case (state_r)
            ST_EXECUTE: begin
                case (opcode_s)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHIFT: begin
                        reg_we_s = onehot4(ir_r[11:10]);
                        wb_sel_s = WB_ALU;
                        inc_pc_s = 1'b1;
                    end
                    OP_MOVE: begin
                        reg_we_s = onehot4(ir_r[11:10]);
                        wb_sel_s = WB_REG;
                        inc_pc_s = 1'b1;
                    end
                    OP_LOADC: begin
                        reg_we_s = onehot4(ir_r[11:10]);
                        wb_sel_s = WB_CONST;
                        inc_pc_s = 1'b1;
                    end
                    OP_STORE: begin
                        load_ram_s = 1'b1;
                        inc_pc_s   = 1'b1;
                    end
                    OP_JUMP: begin
                        if (jump_taken(ir_r[9:8], i_zero, i_neg)) begin
                            load_pc_s = 1'b1;
                        end else begin
                            inc_pc_s = 1'b1;
                        end
                    end
                    default: begin
                        inc_pc_s = 1'b0;
                    end
                endcase
            end
            ST_MEM_WAIT: begin
                reg_we_s = onehot4(ir_r[11:10]);
                wb_sel_s = WB_RAM;
                inc_pc_s = 1'b1;
            end
            default: begin
                inc_pc_s = 1'b0;
            end
        endcase
    end

    // Instruction register: captures the ROM word while in DECODE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ir_r <= 16'h0000;
        end else if (state_r == ST_DECODE) begin
            ir_r <= i_instruction;
        end
    end

    // Sticky illegal-opcode flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            illegal_r <= 1'b0;
        end else if ((state_r == ST_EXECUTE) && (opcode_s >= 4'd10)) begin
            illegal_r <= 1'b1;
        end
    end

    // Retired-instruction counter, wraps naturally at 16 bits
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_r <= 16'h0000;
        end else begin
            count_r <= count_r + {15'd0, (inc_pc_s | load_pc_s)};
        end
    end

    assign o_ir         = ir_r;
    assign o_inc_pc     = inc_pc_s;
    assign o_load_pc    = load_pc_s;
    assign o_load_ram   = load_ram_s;
    assign o_reg_we     = reg_we_s;
    assign o_wb_sel     = wb_sel_s;
    assign o_jump_addr  = INST_ADDR_WIDTH'(ir_r[7:0]);
    assign o_dest_sel   = ir_r[11:10];
    assign o_src_sel    = ir_r[9:8];
    assign o_state      = state_r;
    assign o_halted     = (state_r == ST_HALT);
    assign o_illegal    = illegal_r;
    assign o_inst_count = count_r;

endmodule

// File: tb/tb_sequencer.sv
// Scoreboard bench for sequencer: a driver issues instructions and queues the
// expected strobe pattern; a negedge monitor pops and compares on every strobe.
module tb_sequencer;

    localparam int AW = 8;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_run;
    logic [15:0]   i_instruction;
    logic          i_zero;
    logic          i_neg;
    logic [15:0]   o_ir;
    logic          o_inc_pc;
    logic          o_load_pc;
    logic          o_load_ram;
    logic [AW-1:0] o_jump_addr;
    logic [3:0]    o_reg_we;
    logic [1:0]    o_dest_sel;
    logic [1:0]    o_src_sel;
    logic [1:0]    o_wb_sel;
    logic [2:0]    o_state;
    logic          o_halted;
    logic          o_illegal;
    logic [15:0]   o_inst_count;

    sequencer #(.INST_ADDR_WIDTH(AW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_run(i_run), .i_instruction(i_instruction),
        .i_zero(i_zero), .i_neg(i_neg), .o_ir(o_ir), .o_inc_pc(o_inc_pc),
        .o_load_pc(o_load_pc), .o_load_ram(o_load_ram), .o_jump_addr(o_jump_addr),
        .o_reg_we(o_reg_we), .o_dest_sel(o_dest_sel), .o_src_sel(o_src_sel),
        .o_wb_sel(o_wb_sel), .o_state(o_state), .o_halted(o_halted),
        .o_illegal(o_illegal), .o_inst_count(o_inst_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [3:0]  we;
        logic [1:0]  wb;
        logic        inc;
        logic        ldpc;
        logic        ldram;
        logic [15:0] ir;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] cnt_model = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the strobe set an instruction must produce, or 0 if none
    function automatic bit model(input logic [15:0] ins, input logic z, input logic n, output exp_t e);
        int op;
        int dest;
        int cond;
        bit take;
        op   = int'(ins[15:12]);
        dest = int'(ins[11:10]);
        cond = int'(ins[9:8]);
        e    = '0;
        e.ir = ins;
        if (op >= 10) return 1'b0;
        if (op == 6) begin
            e.ldram = 1'b1;
            e.inc   = 1'b1;
        end else if (op == 8) begin
            take = (cond == 0) || (cond == 1 && z) || (cond == 2 && n);
            e.ldpc = take;
            e.inc  = !take;
        end else begin
            e.we  = 4'(2 ** dest);
            e.wb  = (op == 5) ? 2'd1 : (op == 7) ? 2'd2 : (op == 9) ? 2'd3 : 2'd0;
            e.inc = 1'b1;
        end
        return 1'b1;
    endfunction

    // Monitor: every strobe cycle must match the oldest queued expectation
    always @(negedge i_clk) begin
        if (i_rst_n === 1'b1 && (o_inc_pc || o_load_pc || o_load_ram || (|o_reg_we))) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got inc=%0b ldpc=%0b ldram=%0b we=%b expected none at %0t",
                         o_inc_pc, o_load_pc, o_load_ram, o_reg_we, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("reg_we",     32'(o_reg_we),     32'(mon_e.we));
                chk("wb_sel",     32'(o_wb_sel),     32'(mon_e.wb));
                chk("inc_pc",     32'(o_inc_pc),     32'(mon_e.inc));
                chk("load_pc",    32'(o_load_pc),    32'(mon_e.ldpc));
                chk("load_ram",   32'(o_load_ram),   32'(mon_e.ldram));
                chk("ir",         32'(o_ir),         32'(mon_e.ir));
                chk("dest_sel",   32'(o_dest_sel),   32'(mon_e.ir[11:10]));
                chk("src_sel",    32'(o_src_sel),    32'(mon_e.ir[9:8]));
                chk("jump_addr",  32'(o_jump_addr),  32'(mon_e.ir[7:0]));
                chk("inst_count", 32'(o_inst_count), 32'(cnt_model));
                if (mon_e.inc || mon_e.ldpc) cnt_model = cnt_model + 16'd1;
            end
        end
    end

    // Issue one instruction from FETCH and check latency and end state
    task automatic run_instr(input logic [15:0] ins, input logic z, input logic n);
        exp_t e;
        int   cyc;
        bit   legal;
        int   want;
        i_instruction = ins;
        i_zero        = z;
        i_neg         = n;
        i_run         = 1'b1;
        legal = model(ins, z, n, e);
        if (legal) exp_q.push_back(e);
        want = (ins[15:12] == 4'd5) ? 4 : 3;
        cyc  = 0;
        do begin
            @(posedge i_clk);
            #1;
            cyc++;
            if (cyc == 1) i_run = 1'($urandom_range(0, 1));
            if (cyc == 2) i_instruction = 16'($urandom);
        end while (o_state != 3'd0 && o_state != 3'd4 && cyc < 12);
        chk("latency",   32'(cyc),         32'(want));
        chk("end_state", 32'(o_state),     legal ? 32'd0 : 32'd4);
        chk("pending",   32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        i_rst_n = 1'b0; i_run = 1'b1; i_instruction = 16'h0000; i_zero = 1'b0; i_neg = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_ir",    32'(o_ir),    32'd0);
        chk("rst_count", 32'(o_inst_count), 32'd0);
        chk("rst_outs",  32'({o_inc_pc, o_load_pc, o_load_ram, o_reg_we, o_halted, o_illegal}), 32'd0);
        i_rst_n = 1'b1;

        run_instr(16'h0800, 1'b0, 1'b0);
        run_instr(16'h5400, 1'b0, 1'b0);
        run_instr(16'h6000, 1'b0, 1'b0);
        run_instr(16'h8142, 1'b1, 1'b0);
        run_instr(16'h8142, 1'b0, 1'b1);
        run_instr(16'h8342, 1'b1, 1'b1);
        run_instr(16'h8242, 1'b0, 1'b1);
        run_instr(16'h7E00, 1'b0, 1'b0);
        run_instr(16'h9CFF, 1'b0, 1'b0);

        i_run = 1'b0;
        force dut.count_r = 16'hFFFF;
        @(posedge i_clk);
        #1;
        release dut.count_r;
        cnt_model = 16'hFFFF;
        chk("count_preset", 32'(o_inst_count), 32'h0000FFFF);
        run_instr(16'h0800, 1'b0, 1'b0);
        run_instr(16'h1400, 1'b0, 1'b0);

        for (int k = 0; k < 200; k++) begin
            op = 4'($urandom_range(0, 9));
            run_instr({op, 12'($urandom)}, 1'($urandom), 1'($urandom));
        end

        i_instruction = 16'h0C05; i_run = 1'b1;
        repeat (2) begin
            @(posedge i_clk);
            #1;
        end
        chk("mid_exec_state", 32'(o_state), 32'd2);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_state", 32'(o_state), 32'd0);
        chk("mid_rst_ir",    32'(o_ir),    32'd0);
        chk("mid_rst_count", 32'(o_inst_count), 32'd0);
        chk("mid_rst_outs",  32'({o_inc_pc, o_load_pc, o_load_ram, o_reg_we, o_wb_sel, o_halted, o_illegal}), 32'd0);
        cnt_model = 16'h0000;
        i_run = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        run_instr(16'h3900, 1'b0, 1'b0);
        run_instr(16'h5C00, 1'b0, 1'b0);

        run_instr(16'hA000, 1'b0, 1'b0);
        chk("illegal_set", 32'(o_illegal), 32'd1);
        chk("halted_set",  32'(o_halted),  32'd1);
        for (int k = 0; k < 20; k++) begin
            i_run = 1'($urandom);
            i_instruction = 16'($urandom);
            @(posedge i_clk);
            #1;
            chk("halt_state",   32'(o_state), 32'd4);
            chk("halt_strobes", 32'({o_inc_pc, o_load_pc, o_load_ram, o_reg_we}), 32'd0);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("halt_rst_state",   32'(o_state),   32'd0);
        chk("halt_rst_illegal", 32'(o_illegal), 32'd0);
        chk("halt_rst_halted",  32'(o_halted),  32'd0);
        cnt_model = 16'h0000;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        run_instr(16'h0800, 1'b0, 1'b0);
        run_instr(16'hF123, 1'b0, 1'b0);
        chk("illegal_hi", 32'(o_illegal), 32'd1);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sequencer.md
SEQUENCER -- requirements
Module: sequencer

Interface
REQ-001 Parameter INST_ADDR_WIDTH, default 8, program counter address width; SHALL be at least 8.
REQ-002 i_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  in  1  reset; asynchronous, active-low.
REQ-004 i_run  in  1  run enable, sampled only in FETCH.
REQ-005 i_instruction  in  16  registered program ROM output; valid one cycle after a PC change.
REQ-006 i_zero, i_neg  in  1 each  datapath status flags for conditional jumps.
REQ-007 o_ir  out  16  latched instruction register.
REQ-008 o_inc_pc, o_load_pc, o_load_ram  out  1 each  single-cycle strobes to PC and data RAM.
REQ-009 o_jump_addr  out  INST_ADDR_WIDTH  o_ir[7:0], zero-extended.
REQ-010 o_reg_we  out  4  one-hot register write enable.
REQ-011 o_dest_sel, o_src_sel  out  2 each  equal to o_ir[11:10] and o_ir[9:8].
REQ-012 o_wb_sel  out  2  writeback source: 00 ALU, 01 RAM, 10 register (MOVE), 11 constant (LOADC).
REQ-013 o_state  out  3  current state encoding; o_halted, o_illegal  out  1 each; o_inst_count  out  16.

Function
REQ-014 Opcode SHALL be o_ir[15:12]: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHIFT, 5 LOAD, 6 STORE, 7 MOVE, 8 JUMP, 9 LOADC, 10-15 undefined.
REQ-015 States SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEM_WAIT=3, HALT=4; codes 5-7 SHALL go to HALT on the next edge.
REQ-016 FETCH: SHALL go to DECODE when i_run=1, otherwise hold; no strobes asserted.
REQ-017 DECODE: o_ir SHALL load i_instruction; SHALL go to EXECUTE.
REQ-018 EXECUTE, opcodes 0-4/7/9: SHALL assert o_reg_we bit o_dest_sel, o_wb_sel per REQ-012 (00 for 0-4) and o_inc_pc for one cycle; SHALL go to FETCH.
REQ-019 EXECUTE, STORE: SHALL assert o_load_ram and o_inc_pc for one cycle; o_reg_we SHALL stay 0; SHALL go to FETCH.
REQ-020 EXECUTE, LOAD: no strobes; SHALL go to MEM_WAIT.
REQ-021 MEM_WAIT: SHALL assert o_reg_we bit o_dest_sel, o_wb_sel=01 and o_inc_pc for one cycle; SHALL go to FETCH.
REQ-022 EXECUTE, JUMP: condition o_ir[9:8] = 00 always, 01 i_zero, 10 i_neg, 11 never; true -> o_load_pc, false -> o_inc_pc, one cycle; SHALL go to FETCH.
REQ-023 EXECUTE, opcode 10-15: SHALL set o_illegal (sticky), assert no strobes, go to HALT.
REQ-024 HALT: o_halted=1, all strobes 0; SHALL remain until reset regardless of i_run.
REQ-025 o_inc_pc and o_load_pc SHALL never be asserted in the same cycle; at most one o_reg_we bit SHALL be set.
REQ-026 Latency: 3 cycles per instruction, 4 for LOAD, from FETCH entry to next FETCH entry.
REQ-027 o_inst_count SHALL increment on every cycle with o_inc_pc or o_load_pc, wrapping 0xFFFF -> 0x0000.
REQ-028 i_run deassertion outside FETCH SHALL NOT interrupt the instruction in progress.
REQ-029 All outputs except o_ir-derived selects SHALL be registered or decoded from state only; no combinational path from i_instruction to a strobe.

Reset
REQ-030 i_rst_n=0 SHALL immediately force state FETCH, o_ir=0, o_inst_count=0, o_illegal=0, o_halted=0, all strobes and o_reg_we=0, including mid-instruction and from HALT.
REQ-031 After i_rst_n rises, the first DECODE SHALL occur no earlier than the second rising edge, giving the ROM one read cycle.

Verification
REQ-032 ADD r2 (0x0800), i_run=1 -> o_reg_we=0100, o_wb_sel=00, o_inc_pc at cycle 3; back in FETCH at cycle 4.
REQ-033 LOAD r1 (0x5400) -> MEM_WAIT entered; o_reg_we=0010, o_wb_sel=01, o_inc_pc one cycle later; STORE (0x6000) -> o_load_ram=1, o_reg_we=0000.
REQ-034 JUMP 0x8142 with i_zero=1 -> o_load_pc=1, o_jump_addr=0x42; with i_zero=0 -> o_inc_pc=1; 0x8342 -> never jumps.
REQ-035 Opcode 0xA000 -> o_illegal=1, state HALT, no strobes for 20 cycles; i_rst_n pulse -> FETCH, o_illegal=0.
REQ-036 o_inst_count preset via 65535 executed instructions -> next strobe wraps to 0; i_rst_n asserted in EXECUTE -> no strobe that cycle, all outputs zero.
